// File: rtl/t2_pkg.sv
// Shared constants and types for the Task 2 binary-search block (loader and controller).
package t2_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32'(1) << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_LAST = 2'd2,
        LD_DONE = 2'd3
    } loader_state_t;

    // Registered RAM write port payload.
    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_wr_t;

    // True when the beat being accepted fills the final RAM word.
    function automatic logic is_last_beat(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(DEPTH - 1);
    endfunction

endpackage

// File: rtl/t2_order_check.sv
// Non-decreasing order checker: remembers the previous accepted byte and raises a sticky
// error flag when a later byte is smaller. Cleared at the start of each fill.
module t2_order_check
    import t2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat,
    input  logic              first,
    input  logic [DATA_W-1:0] data,
    output logic              sort_err
);

    logic [DATA_W-1:0] prev_q;
    logic              err_q;
    logic              err_set_c;

    // The first byte of a fill has no predecessor; equal bytes are legal.
    assign err_set_c = beat & ~first & (data < prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (clear) begin
                err_q <= 1'b0;
            end else if (err_set_c) begin
                err_q <= 1'b1;
            end
            if (beat) begin
                prev_q <= data;
            end
        end
    end

    assign sort_err = err_q;

endmodule

// File: rtl/t2_ram_loader.sv
// Fills the 32x8 search RAM from a valid/ready byte stream, then hands the RAM address to the
// search datapath. Optional order checking is enabled with `define T2_LOADER_SORT_CHECK_EN.
module t2_ram_loader
    import t2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] search_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              load_done,
    output logic              sort_err,
    output logic              search_en
);

    loader_state_t    state_q;
    ram_wr_t          wr_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             srch_en_q;

    logic             beat_c;
    logic             fill_start_c;

    // abort has priority over both a same-cycle beat and a same-cycle start.
    assign beat_c       = in_valid & (state_q == LD_LOAD) & ~abort;
    assign fill_start_c = start & ~abort & ((state_q == LD_IDLE) | (state_q == LD_DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LD_IDLE;
            wr_q      <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            srch_en_q <= 1'b0;
        end else begin
            wr_q.wren <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (fill_start_c) begin
                        state_q <= LD_LOAD;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LD_LOAD: begin
                    if (abort) begin
                        state_q <= LD_IDLE;
                        busy_q  <= 1'b0;
                    end else if (beat_c) begin
                        wr_q.wren  <= 1'b1;
                        wr_q.addr  <= count_q[ADDR_W-1:0];
                        wr_q.wdata <= in_data;
                        count_q    <= count_q + CNT_W'(1);
                        if (is_last_beat(count_q)) begin
                            state_q <= LD_LAST;
                        end
                    end
                end
                LD_LAST: begin
                    // The final write is already on the port and lands at this edge.
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q <= LD_IDLE;
                    end else begin
                        state_q   <= LD_DONE;
                        done_q    <= 1'b1;
                        srch_en_q <= ~sort_err;
                    end
                end
                LD_DONE: begin
                    if (abort) begin
                        state_q   <= LD_IDLE;
                        done_q    <= 1'b0;
                        srch_en_q <= 1'b0;
                    end else if (fill_start_c) begin
                        state_q   <= LD_LOAD;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        srch_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef T2_LOADER_SORT_CHECK_EN
    logic first_c;

    assign first_c = (count_q == '0);

    t2_order_check u_order_check (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (fill_start_c),
        .beat     (beat_c),
        .first    (first_c),
        .data     (in_data),
        .sort_err (sort_err)
    );
`else
    assign sort_err = 1'b0;
`endif

    // In DONE the search datapath owns the RAM address port.
    assign ram_addr  = (state_q == LD_DONE) ? search_addr : wr_q.addr;
    assign in_ready  = (state_q == LD_LOAD);
    assign ram_wdata = wr_q.wdata;
    assign ram_wren  = wr_q.wren;
    assign count     = count_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign search_en = srch_en_q;

endmodule
